// File: rtl/mem_access_unit.sv
// Load/store unit: byte/halfword/word accesses to a word-wide memory,
// with read-modify-write for sub-word stores and alignment checking.
module mem_access_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [31:0] mem_rdata,
   output logic [31:0] mem_addr,
   output logic        mem_wr,
   output logic [31:0] mem_wdata,
   output logic [31:0] rdata,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WAIT,
      S_WRITE,
      S_DONE
   } state_t;

   localparam logic [2:0] OP_LW = 3'b000;
   localparam logic [2:0] OP_LH = 3'b001;
   localparam logic [2:0] OP_LB = 3'b010;
   localparam logic [2:0] OP_SW = 3'b100;
   localparam logic [2:0] OP_SH = 3'b101;
   localparam logic [2:0] OP_SB = 3'b110;

   state_t      r_state;
   logic [2:0]  r_op;
   logic [1:0]  r_lane;
   logic [31:0] r_wdata;
   logic [31:0] r_merge;
   logic [31:0] r_mem_addr;
   logic [31:0] r_mem_wdata;
   logic [31:0] r_rdata;
   logic        r_mem_wr;
   logic        r_busy;
   logic        r_done;
   logic        r_err;

   logic        w_bad;
   logic [31:0] w_shift;
   logic [31:0] w_load;
   logic [31:0] w_merge;

   // Classify the incoming request: illegal opcode or misaligned address
   always_comb begin
      w_bad = 1'b0;
      case (op)
         OP_LW, OP_SW: w_bad = (addr[1:0] != 2'b00);
         OP_LH, OP_SH: w_bad = addr[0];
         OP_LB, OP_SB: w_bad = 1'b0;
         default:      w_bad = 1'b1;
      endcase
   end

   // Extract the addressed lane(s) from the read word, zero-extended
   always_comb begin
      w_shift = mem_rdata >> {r_lane, 3'b000};
      w_load  = mem_rdata;
      case (r_op[1:0])
         2'b01:   w_load = {16'h0000, w_shift[15:0]};
         2'b10:   w_load = {24'h000000, w_shift[7:0]};
         default: w_load = mem_rdata;
      endcase
   end

   // Replace only the addressed lane(s) of the read word with store data
   always_comb begin
      w_merge = mem_rdata;
      case (r_op[1:0])
         2'b01: begin
            if (r_lane[1])
               w_merge[31:16] = r_wdata[15:0];
            else
               w_merge[15:0] = r_wdata[15:0];
         end
         2'b10:   w_merge[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
         default: w_merge = mem_rdata;
      endcase
   end

   // Access sequencer with registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_op        <= 3'b000;
         r_lane      <= 2'b00;
         r_wdata     <= 32'h0;
         r_merge     <= 32'h0;
         r_mem_addr  <= 32'h0;
         r_mem_wdata <= 32'h0;
         r_rdata     <= 32'h0;
         r_mem_wr    <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_op       <= op;
                  r_lane     <= addr[1:0];
                  r_wdata    <= wdata;
                  r_mem_addr <= {addr[31:2], 2'b00};
                  r_err      <= w_bad;
                  if (w_bad) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else if (op == OP_SW) begin
                     r_state     <= S_WRITE;
                     r_mem_wr    <= 1'b1;
                     r_mem_wdata <= wdata;
                     r_busy      <= 1'b1;
                  end else begin
                     r_state <= S_READ;
                     r_busy  <= 1'b1;
                  end
               end
            end
            S_READ: begin
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (r_op[2]) begin
                  r_merge     <= w_merge;
                  r_mem_wdata <= w_merge;
                  r_mem_wr    <= 1'b1;
                  r_state     <= S_WRITE;
               end else begin
                  r_rdata <= w_load;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            S_WRITE: begin
               r_mem_wr <= 1'b0;
               r_busy   <= 1'b0;
               r_done   <= 1'b1;
               r_state  <= S_DONE;
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_mem_wr <= 1'b0;
               r_busy   <= 1'b0;
               r_done   <= 1'b0;
               r_state  <= S_IDLE;
            end
         endcase
      end
   end

   // Reset gates the write strobe immediately so an interrupted write never commits
   assign mem_wr    = r_mem_wr & ~reset;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign rdata     = r_rdata;
   assign busy      = r_busy;
   assign done      = r_done;
   assign err       = r_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: vector table driven through a scoreboard
// queue, plus reset-during-write and back-to-back sequences.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] mem_rdata;
   logic [31:0] mem_addr;
   logic        mem_wr;
   logic [31:0] mem_wdata;
   logic [31:0] rdata;
   logic        busy;
   logic        done;
   logic        err;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] mem [0:255];

   typedef struct {
      logic [2:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] pre;
      logic        pre_en;
      logic [31:0] exp_rd;
      logic        exp_err;
      int          lat;
      int          nwr;
      logic [31:0] exp_wd;
      logic [31:0] exp_mem;
   } vec_t;

   vec_t q[$];
   vec_t vecs[16];

   mem_access_unit dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .addr      (addr),
      .wdata     (wdata),
      .mem_rdata (mem_rdata),
      .mem_addr  (mem_addr),
      .mem_wr    (mem_wr),
      .mem_wdata (mem_wdata),
      .rdata     (rdata),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   // Synchronous memory: read data appears the cycle after the address
   always @(posedge clk) begin
      if (mem_wr)
         mem[mem_addr[9:2]] <= mem_wdata;
      mem_rdata <= mem[mem_addr[9:2]];
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input bit hold);
      vec_t        e;
      int          cyc;
      int          nwr;
      int          wrcyc;
      logic [31:0] wd;
      bit          got;
      if (v.pre_en)
         mem[v.addr[9:2]] = v.pre;
      @(negedge clk);
      start = 1'b1;
      op    = v.op;
      addr  = v.addr;
      wdata = v.wdata;
      q.push_back(v);
      @(posedge clk);
      #1;
      if (!hold)
         start = 1'b0;
      cyc   = 1;
      nwr   = 0;
      wrcyc = 0;
      wd    = 32'h0;
      got   = 1'b0;
      while (cyc <= 12) begin
         if (mem_wr) begin
            nwr++;
            wrcyc = cyc;
            wd    = mem_wdata;
         end
         if (done) begin
            got = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      e = q.pop_front();
      chk("done_seen", 32'(got), 32'd1);
      chk("latency", 32'(cyc), 32'(e.lat));
      chk("err", 32'(err), 32'(e.exp_err));
      chk("rdata", rdata, e.exp_rd);
      chk("wr_pulses", 32'(nwr), 32'(e.nwr));
      chk("mem_addr", mem_addr, {e.addr[31:2], 2'b00});
      if (e.nwr > 0) begin
         chk("wr_cycle", 32'(wrcyc), 32'(e.lat - 1));
         chk("mem_wdata", wd, e.exp_wd);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      chk("mem_word", mem[e.addr[9:2]], e.exp_mem);
   endtask

   initial begin
      vec_t v;
      int   cyc;

      for (int i = 0; i < 256; i++)
         mem[i] = 32'h0;
      reset = 1'b1;
      start = 1'b0;
      op    = 3'b000;
      addr  = 32'h0;
      wdata = 32'h0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_mem_wr", 32'(mem_wr), 32'd0);

      // Reset wins over a simultaneous start
      @(negedge clk);
      start = 1'b1;
      op    = 3'b000;
      addr  = 32'h40;
      @(posedge clk);
      #1;
      chk("rst_prio_busy", 32'(busy), 32'd0);
      chk("rst_prio_done", 32'(done), 32'd0);
      @(negedge clk);
      start = 1'b0;
      reset = 1'b0;

      vecs[0]  = '{3'b000, 32'h40, 32'h0, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b0, 3, 0, 32'h0, 32'hDEADBEEF};
      vecs[1]  = '{3'b010, 32'hFF, 32'h0, 32'h11223344, 1'b1, 32'h00000011, 1'b0, 3, 0, 32'h0, 32'h11223344};
      vecs[2]  = '{3'b010, 32'hFD, 32'h0, 32'h11223344, 1'b1, 32'h00000033, 1'b0, 3, 0, 32'h0, 32'h11223344};
      vecs[3]  = '{3'b110, 32'h11, 32'h12345677, 32'hAABBCCDD, 1'b1, 32'h00000033, 1'b0, 4, 1, 32'hAABB77DD, 32'hAABB77DD};
      vecs[4]  = '{3'b001, 32'h21, 32'h0, 32'h0, 1'b1, 32'h00000033, 1'b1, 1, 0, 32'h0, 32'h0};
      vecs[5]  = '{3'b001, 32'h32, 32'h0, 32'hCAFEF00D, 1'b1, 32'h0000CAFE, 1'b0, 3, 0, 32'h0, 32'hCAFEF00D};
      vecs[6]  = '{3'b001, 32'h30, 32'h0, 32'hCAFEF00D, 1'b1, 32'h0000F00D, 1'b0, 3, 0, 32'h0, 32'hCAFEF00D};
      vecs[7]  = '{3'b101, 32'h36, 32'h0000BEEF, 32'h11112222, 1'b1, 32'h0000F00D, 1'b0, 4, 1, 32'hBEEF2222, 32'hBEEF2222};
      vecs[8]  = '{3'b100, 32'h50, 32'h01234567, 32'hFFFFFFFF, 1'b1, 32'h0000F00D, 1'b0, 2, 1, 32'h01234567, 32'h01234567};
      vecs[9]  = '{3'b100, 32'h52, 32'h77777777, 32'hA5A5A5A5, 1'b1, 32'h0000F00D, 1'b1, 1, 0, 32'h0, 32'hA5A5A5A5};
      vecs[10] = '{3'b011, 32'h60, 32'h0, 32'h0, 1'b1, 32'h0000F00D, 1'b1, 1, 0, 32'h0, 32'h0};
      vecs[11] = '{3'b000, 32'h61, 32'h0, 32'h0, 1'b1, 32'h0000F00D, 1'b1, 1, 0, 32'h0, 32'h0};
      vecs[12] = '{3'b010, 32'h62, 32'h0, 32'h89ABCDEF, 1'b1, 32'h000000AB, 1'b0, 3, 0, 32'h0, 32'h89ABCDEF};
      vecs[13] = '{3'b110, 32'h70, 32'hFFFFFFFF, 32'h0, 1'b1, 32'h000000AB, 1'b0, 4, 1, 32'h000000FF, 32'h000000FF};
      vecs[14] = '{3'b110, 32'h73, 32'h0000005A, 32'h12345678, 1'b1, 32'h000000AB, 1'b0, 4, 1, 32'h5A345678, 32'h5A345678};
      vecs[15] = '{3'b111, 32'h80, 32'h0, 32'h0, 1'b1, 32'h000000AB, 1'b1, 1, 0, 32'h0, 32'h0};

      for (int i = 0; i < 16; i++)
         run_vec(vecs[i], 1'b0);

      // Reset arriving in the WRITE cycle of an SH must block the write
      mem[8] = 32'h01020304;
      @(negedge clk);
      start = 1'b1;
      op    = 3'b101;
      addr  = 32'h22;
      wdata = 32'h0000BEEF;
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc   = 1;
      while (!mem_wr && cyc < 6) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk("rstw_wr_cycle", 32'(cyc), 32'd3);
      reset = 1'b1;
      #1;
      chk("rstw_mem_wr", 32'(mem_wr), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rstw_mem_addr", mem_addr, 32'h0);
      chk("rstw_mem_wdata", mem_wdata, 32'h0);
      chk("rstw_rdata", rdata, 32'h0);
      chk("rstw_busy", 32'(busy), 32'd0);
      chk("rstw_done", 32'(done), 32'd0);
      chk("rstw_err", 32'(err), 32'd0);
      chk("rstw_mem", mem[8], 32'h01020304);
      @(posedge clk);
      #1;
      chk("rstw_idle", 32'(busy), 32'd0);

      // Back-to-back SW then LW, start held through DONE on the SW
      v = '{3'b100, 32'h0, 32'h5, 32'h0, 1'b1, 32'h0, 1'b0, 2, 1, 32'h5, 32'h5};
      run_vec(v, 1'b1);
      v = '{3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 32'h5, 1'b0, 3, 0, 32'h0, 32'h5};
      run_vec(v, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
